// File: rtl/piso_pkg.sv
// Shared constants and helpers for the PISO shift register slice.
package piso_pkg;

  localparam int   PISO_DEFAULT_WIDTH = 8;
  localparam logic PISO_IDLE_LEVEL    = 1'b0;

  // Wide enough to hold a count of width+1, which the parity frame needs.
  function automatic int piso_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: loadable down-counter with zero flag, also registers busy and done.
module piso_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] count;

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (load) begin
        count <= load_val;
      end else if (dec_en && !zero) begin
        count <= count - CNT_W'(1);
      end
      busy <= load || !zero;
      // The last bit appears on the line on the edge that takes the count from 1 to 0.
      done <= !load && dec_en && (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register, MSB first on a registered serial line.
// Define PISO_PARITY_EN to append an even-parity bit after bit 0 of every frame.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int   WIDTH      = PISO_DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = PISO_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = piso_cnt_width(WIDTH);

`ifdef PISO_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
  logic tail_bit;
  assign tail_bit = ^parallel_in;
`else
  localparam int FRAME_BITS = WIDTH;
  logic tail_bit;
  assign tail_bit = 1'b0;
`endif

  // The MSB goes straight to the line on capture, so the counter holds bits still to send.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(FRAME_BITS - 1);

  logic [WIDTH-1:0] shreg;
  logic             cnt_zero;

  piso_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (LOAD_VAL),
    .dec_en   (!load),
    .zero     (cnt_zero),
    .busy     (busy),
    .done     (done)
  );

  // The tail bit (parity or filler) rides in the LSB behind the remaining data bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg      <= '0;
      serial_out <= IDLE_LEVEL;
    end else if (load) begin
      serial_out <= parallel_in[WIDTH-1];
      shreg      <= {parallel_in[WIDTH-2:0], tail_bit};
    end else if (!cnt_zero) begin
      serial_out <= shreg[WIDTH-1];
      shreg      <= {shreg[WIDTH-2:0], 1'b0};
    end else begin
      serial_out <= IDLE_LEVEL;
    end
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: directed frames plus random loads against a frame model.
module tb_piso_shift_reg;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] parallel_in = '0;
  logic         serial_out, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: the current frame word and which of its bits is on the line.
  logic [W-1:0] m_word = '0;
  bit           m_active = 1'b0;
  int           m_pos = 0;

  piso_shift_reg #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .parallel_in (parallel_in),
    .serial_out  (serial_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [W-1:0] word, input int pos);
    if (pos < W) return word[W-1-pos];
    return ^word;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".serial"}, 32'(serial_out), m_active ? 32'(frame_bit(m_word, m_pos)) : 32'd0);
    check_eq({tag, ".busy"}, 32'(busy), 32'(m_active));
    check_eq({tag, ".done"}, 32'(done), 32'(m_active && (m_pos == FRAME - 1)));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".serial"}, 32'(serial_out), 32'd0);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".done"}, 32'(done), 32'd0);
  endtask

  // Called at a negedge: drive inputs, advance model on the posedge, check at the next negedge.
  task automatic tick(input string tag, input logic ld, input logic [W-1:0] din);
    load        = ld;
    parallel_in = din;
    @(posedge clk);
    if (ld) begin
      m_word   = din;
      m_active = 1'b1;
      m_pos    = 0;
    end else if (m_active) begin
      if (m_pos < FRAME - 1) m_pos++;
      else m_active = 1'b0;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic run_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 1'b0, 8'($urandom));
  endtask

  initial begin
    // Reset held with an active load request: nothing may leak out.
    rst = 1'b0; load = 1'b1; parallel_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_reset_state("reset_hold");
    end
    load = 1'b0;
    rst  = 1'b1;
    run_idle("idle0", 2);

    tick("a5", 1'b1, 8'hA5);
    run_idle("a5", FRAME + 2);

    tick("b2b_81", 1'b1, 8'h81);
    run_idle("b2b_81", FRAME - 1);
    tick("b2b_3c", 1'b1, 8'h3C);
    run_idle("b2b_3c", FRAME + 1);

    tick("reload_ff", 1'b1, 8'hFF);
    run_idle("reload_ff", 2);
    tick("reload_00", 1'b1, 8'h00);
    run_idle("reload_00", FRAME + 1);

    tick("par_07", 1'b1, 8'h07);
    run_idle("par_07", FRAME + 1);

    // Asynchronous reset in the middle of a frame, between clock edges.
    tick("rst_f0", 1'b1, 8'hF0);
    run_idle("rst_f0", 1);
    #2 rst = 1'b0;
    #1 check_reset_state("rst_async");
    m_active = 1'b0;
    @(posedge clk); @(negedge clk);
    check_reset_state("rst_held");
    rst = 1'b1;
    run_idle("rst_idle", FRAME + 2);

    // Random loads, including back-to-back and mid-frame reloads.
    for (int i = 0; i < 400; i++) begin
      tick("rand", ($urandom_range(0, 5) == 0), 8'($urandom));
    end
    run_idle("drain", FRAME + 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
